// File: rtl/instruction_loader.sv
// Boot-time program loader: receives a length-prefixed, XOR-checksummed byte stream,
// writes 48-bit instructions to instruction memory from address 0, and holds the CPU in reset until the image checks out.
module instruction_loader #(
    parameter int INSTRUCTION_WIDTH = 48,
    parameter int BYTE_WIDTH        = 8,
    parameter int ADDRESS_WIDTH     = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         byteValid,
    input  logic [BYTE_WIDTH-1:0]        byteData,
    output logic                         byteReady,
    output logic                         memWriteEnable,
    output logic [ADDRESS_WIDTH-1:0]     memWriteAddress,
    output logic [INSTRUCTION_WIDTH-1:0] memWriteData,
    output logic                         cpuReset,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [2:0]                   debug_state
);

    // Handshake: a byte moves on the rising edge where byteValid && byteReady are both 1.
    // byteReady is decoded from state alone, so it never depends on byteValid or byteData.

    localparam int          BYTES_PER_WORD = INSTRUCTION_WIDTH / BYTE_WIDTH;
    localparam int          LENGTH_WIDTH   = 2 * BYTE_WIDTH;
    localparam logic [31:0] CAPACITY       = 32'd1 << ADDRESS_WIDTH;
    localparam logic [2:0]  LAST_BYTE      = 3'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        PAYLOAD = 3'd3,
        WRITE   = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_t;

    state_t                       state;
    state_t                       next_state;
    logic [LENGTH_WIDTH-1:0]      length;
    logic [LENGTH_WIDTH-1:0]      length_in;
    logic [ADDRESS_WIDTH:0]       word_index;
    logic [2:0]                   byte_index;
    logic [BYTE_WIDTH-1:0]        checksum;
    logic [INSTRUCTION_WIDTH-1:0] shift;
    logic                         transfer;
    logic                         length_bad;
    logic                         last_word;

    assign transfer   = byteValid && byteReady;
    assign length_in  = {length[LENGTH_WIDTH-1 -: BYTE_WIDTH], byteData};
    assign length_bad = (length_in == '0) || (32'(length_in) > CAPACITY);
    // word_index carries one extra bit so a full-capacity image compares correctly
    assign last_word  = (32'(word_index) + 32'd1) == 32'(length);

    assign memWriteAddress = word_index[ADDRESS_WIDTH-1:0];
    assign memWriteData    = shift;
    assign debug_state     = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE, ERROR: if (start) next_state = LEN_HI;
            LEN_HI:            if (transfer) next_state = LEN_LO;
            LEN_LO: begin
                if (transfer) next_state = length_bad ? ERROR : PAYLOAD;
            end
            PAYLOAD:           if (transfer && byte_index == LAST_BYTE) next_state = WRITE;
            WRITE:             next_state = last_word ? CHECK : PAYLOAD;
            CHECK: begin
                if (transfer) next_state = (byteData == checksum) ? DONE : ERROR;
            end
            default:           next_state = IDLE;
        endcase
    end

    always_comb begin
        byteReady      = 1'b0;
        memWriteEnable = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        cpuReset       = 1'b1;
        case (state)
            LEN_HI, LEN_LO, PAYLOAD, CHECK: begin
                byteReady = 1'b1;
                busy      = 1'b1;
            end
            WRITE: begin
                memWriteEnable = 1'b1;
                busy           = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                cpuReset = 1'b0;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            length     <= '0;
            word_index <= '0;
            byte_index <= '0;
            checksum   <= '0;
            shift      <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        word_index <= '0;
                        byte_index <= '0;
                        checksum   <= '0;
                    end
                end
                LEN_HI: if (transfer) length[LENGTH_WIDTH-1 -: BYTE_WIDTH] <= byteData;
                LEN_LO: if (transfer) length <= length_in;
                PAYLOAD: begin
                    if (transfer) begin
                        shift      <= {shift[INSTRUCTION_WIDTH-BYTE_WIDTH-1:0], byteData};
                        checksum   <= checksum ^ byteData;
                        byte_index <= (byte_index == LAST_BYTE) ? 3'd0 : byte_index + 3'd1;
                    end
                end
                WRITE:   word_index <= word_index + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: table of whole-frame loads plus hand sequences for
// latency, reload, error clearing, start-while-busy and reset in mid-payload.
module tb_instruction_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        byteValid;
    logic [7:0]  byteData;
    logic        byteReady;
    logic        memWriteEnable;
    logic [9:0]  memWriteAddress;
    logic [47:0] memWriteData;
    logic        cpuReset;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  debug_state;

    instruction_loader #(
        .INSTRUCTION_WIDTH(48),
        .BYTE_WIDTH(8),
        .ADDRESS_WIDTH(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .byteValid(byteValid),
        .byteData(byteData),
        .byteReady(byteReady),
        .memWriteEnable(memWriteEnable),
        .memWriteAddress(memWriteAddress),
        .memWriteData(memWriteData),
        .cpuReset(cpuReset),
        .busy(busy),
        .done(done),
        .error(error),
        .debug_state(debug_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] n;
        logic [47:0] w0;
        logic [47:0] w1;
        logic [47:0] w2;
        logic [7:0]  chk_mask;
        bit          gaps;
        int          exp_writes;
        bit          exp_done;
        bit          exp_error;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cycle = 0;
    logic [57:0] exp_q[$];
    logic [7:0]  frame[$];

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Write scoreboard plus the ready/write relationship, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (memWriteEnable === 1'b1) begin
                check("write_was_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    check("write_addr_data", 64'({memWriteAddress, memWriteData}), 64'(exp_q.pop_front()));
            end
            if (busy === 1'b1)
                check("ready_low_only_in_write", 64'(byteReady), 64'(!memWriteEnable));
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start_cycle = cyc;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                byteValid = 1'b0;
                @(posedge clock); #1;
            end
        end
        byteValid = 1'b1;
        byteData  = b;
        budget    = 0;
        while (byteReady !== 1'b1 && budget < 50) begin
            @(posedge clock); #1;
            budget++;
        end
        if (budget >= 50) check("byte_ready_timeout", 64'(byteReady), 64'd1);
        @(posedge clock); #1;
    endtask

    task automatic build_frame(input vec_t v);
        logic [47:0] w;
        logic [7:0]  b;
        logic [7:0]  chk;
        frame.delete();
        chk = 8'h00;
        frame.push_back(v.n[15:8]);
        frame.push_back(v.n[7:0]);
        for (int i = 0; i < v.exp_writes; i++) begin
            if (i == 0)      w = v.w0;
            else if (i == 1) w = v.w1;
            else if (i == 2) w = v.w2;
            else             w = {16'($urandom), $urandom};
            exp_q.push_back({10'(i), w});
            for (int j = 5; j >= 0; j--) begin
                b = w[j*8 +: 8];
                frame.push_back(b);
                chk ^= b;
            end
        end
        if (v.exp_writes > 0) frame.push_back(chk ^ v.chk_mask);
    endtask

    task automatic send_frame(input bit gaps);
        foreach (frame[i]) send_byte(frame[i], gaps);
        byteValid = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (busy === 1'b1 && budget < 50) begin
            @(posedge clock); #1;
            budget++;
        end
        check("idle_after_frame", 64'(busy), 64'd0);
    endtask

    vec_t vecs[7];
    vec_t v;

    initial begin
        vecs[0] = '{16'd1,      48'h123456789ABC, 48'h0, 48'h0, 8'h00, 1'b0, 1,    1'b1, 1'b0};
        vecs[1] = '{16'd1,      48'h123456789ABC, 48'h0, 48'h0, 8'h01, 1'b0, 1,    1'b0, 1'b1};
        vecs[2] = '{16'd0,      48'h0, 48'h0, 48'h0,            8'h00, 1'b0, 0,    1'b0, 1'b1};
        vecs[3] = '{16'h0401,   48'h0, 48'h0, 48'h0,            8'h00, 1'b0, 0,    1'b0, 1'b1};
        vecs[4] = '{16'd3,      48'h010203040506, 48'hA0B0C0D0E0F0, 48'hFFEEDDCCBBAA, 8'h00, 1'b1, 3, 1'b1, 1'b0};
        vecs[5] = '{16'd2,      48'hDEADBEEF0001, 48'h000000000000, 48'h0, 8'h80, 1'b0, 2, 1'b0, 1'b1};
        vecs[6] = '{16'h0400,   48'h0F1E2D3C4B5A, 48'h998877665544, 48'h13579BDF0246, 8'h00, 1'b0, 1024, 1'b1, 1'b0};

        reset     = 1'b1;
        start     = 1'b0;
        byteValid = 1'b0;
        byteData  = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("reset_byteReady", 64'(byteReady), 64'd0);
        check("reset_memWriteEnable", 64'(memWriteEnable), 64'd0);
        check("reset_memWriteAddress", 64'(memWriteAddress), 64'd0);
        check("reset_memWriteData", 64'(memWriteData), 64'd0);
        check("reset_cpuReset", 64'(cpuReset), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        check("reset_state_idle", 64'(debug_state), 64'd0);

        // Byte held in IDLE is not consumed and nothing is written.
        byteValid = 1'b1;
        byteData  = 8'h55;
        repeat (3) @(posedge clock);
        #1 byteValid = 1'b0;
        check("idle_ignores_bytes", 64'(debug_state), 64'd0);

        // Single instruction with exact latency: done visible after edge k+10.
        build_frame(vecs[0]);
        do_start();
        send_frame(1'b0);
        check("latency_cycles", 64'(cyc - start_cycle), 64'd10);
        check("latency_done", 64'(done), 64'd1);
        check("latency_cpuReset", 64'(cpuReset), 64'd0);
        check("latency_busy", 64'(busy), 64'd0);
        check("latency_writes_drained", 64'(exp_q.size()), 64'd0);

        for (int t = 0; t < 7; t++) begin
            v = vecs[t];
            build_frame(v);
            do_start();
            send_frame(v.gaps);
            wait_idle();
            check($sformatf("t%0d_done", t), 64'(done), 64'(v.exp_done));
            check($sformatf("t%0d_error", t), 64'(error), 64'(v.exp_error));
            check($sformatf("t%0d_cpuReset", t), 64'(cpuReset), 64'(!v.exp_done));
            check($sformatf("t%0d_writes_drained", t), 64'(exp_q.size()), 64'd0);
        end

        // Reload after success: flags flip the next cycle, image overwrites from address 0.
        v = '{16'd1, 48'hCAFEF00D1234, 48'h0, 48'h0, 8'h00, 1'b0, 1, 1'b1, 1'b0};
        build_frame(v);
        do_start();
        check("reload_done_cleared", 64'(done), 64'd0);
        check("reload_cpuReset", 64'(cpuReset), 64'd1);
        check("reload_busy", 64'(busy), 64'd1);
        send_frame(1'b0);
        wait_idle();
        check("reload_done", 64'(done), 64'd1);
        check("reload_writes_drained", 64'(exp_q.size()), 64'd0);

        // Error, then a new start clears it; a second start while busy changes nothing.
        build_frame(vecs[2]);
        do_start();
        send_frame(1'b0);
        wait_idle();
        check("zero_len_error", 64'(error), 64'd1);
        do_start();
        check("start_clears_error", 64'(error), 64'd0);
        check("start_sets_busy", 64'(busy), 64'd1);
        check("start_sets_cpuReset", 64'(cpuReset), 64'd1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("start_while_busy_ignored", 64'(debug_state), 64'd1);

        // Reset after the 3rd payload byte of word 1: word 0 is written, word 1 never is.
        exp_q.push_back({10'd0, 48'h112233445566});
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        send_byte(8'h99, 1'b0);
        byteData = 8'hAA;
        reset    = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midreset_state_idle", 64'(debug_state), 64'd0);
        check("midreset_cpuReset", 64'(cpuReset), 64'd1);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_byteReady", 64'(byteReady), 64'd0);
        repeat (10) @(posedge clock);
        #1 byteValid = 1'b0;
        check("midreset_stays_idle", 64'(debug_state), 64'd0);
        check("midreset_word0_only", 64'(exp_q.size()), 64'd0);

        // start in the same cycle as reset is ignored.
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clock); #1;
        check("start_with_reset_ignored", 64'(debug_state), 64'd0);
        check("start_with_reset_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
